// File: rtl/gtfmac_vnc_rx_chk_pkg.sv
//==============================================================================
// Module : gtfmac_vnc_rx_chk_pkg
// Desc   : Shared types and constants for the RX VNC packet checker.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package gtfmac_vnc_rx_chk_pkg;

    localparam int c_cnt_w_def = 32;
    localparam int c_len_w_def = 14;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IN_FRAME = 2'd1,
        SKIP     = 2'd2
    } chk_state_t;

    localparam int c_sts_under = 0;
    localparam int c_sts_over  = 1;
    localparam int c_sts_pld   = 2;
    localparam int c_sts_err   = 3;
    localparam int c_sts_proto = 4;

    typedef struct packed {
        logic proto;
        logic err;
        logic pld;
        logic over;
        logic under;
    } frm_status_t;

endpackage

`default_nettype wire

// File: rtl/gtfmac_vnc_sat_cnt.sv
//==============================================================================
// Module : gtfmac_vnc_sat_cnt
// Desc   : Saturating up-counter with synchronous clear (clear beats increment).
// Rev    : 1.0
//==============================================================================
`default_nettype none

module gtfmac_vnc_sat_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/gtfmac_vnc_rx_pkt_chk.sv
//==============================================================================
// Module : gtfmac_vnc_rx_pkt_chk
// Desc   : RX frame checker: length limits, incrementing payload pattern,
//          per-frame status and saturating stats. Payload check enabled by
//          macro GTFMAC_VNC_RX_CHK_PLD_EN.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module gtfmac_vnc_rx_pkt_chk
    import gtfmac_vnc_rx_chk_pkg::*;
#(
    parameter int CNT_W   = c_cnt_w_def,
    parameter int PLD_OFS = 14,
    parameter int LEN_W   = c_len_w_def
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_ena,
    input  logic             din_sop,
    input  logic [63:0]      din_data,
    input  logic             din_eop,
    input  logic [2:0]       din_mty,
    input  logic             din_err,
    input  logic             din_empty,
    input  logic             ctl_vnc_mon_en,
    input  logic [LEN_W-1:0] ctl_vnc_min_len,
    input  logic [LEN_W-1:0] ctl_vnc_max_len,
    input  logic             clr_cnt,
    output logic             frm_done,
    output logic [LEN_W-1:0] frm_len,
    output logic [4:0]       frm_status,
    output logic [CNT_W-1:0] cnt_good,
    output logic [CNT_W-1:0] cnt_under,
    output logic [CNT_W-1:0] cnt_over,
    output logic [CNT_W-1:0] cnt_pld_err,
    output logic [CNT_W-1:0] cnt_err,
    output logic [CNT_W-1:0] cnt_proto
);

    chk_state_t r_state, w_state_nxt;

    logic             w_acc;
    logic [3:0]       w_nbytes;
    logic             w_start, w_cont, w_done, w_proto_evt, w_start_proto;

    logic [LEN_W-1:0] r_len;
    logic             r_sat;
    logic             r_proto;
    logic [LEN_W-1:0] w_base;
    logic             w_base_sat;
    logic [LEN_W:0]   w_sum;
    logic [LEN_W-1:0] w_len_nxt;
    logic             w_sat_nxt;
    logic             w_pld_nxt;

    logic             r_frm_done;
    logic [LEN_W-1:0] r_frm_len;
    frm_status_t      r_frm_status;

    assign w_acc    = din_ena & ~din_empty;
    assign w_nbytes = din_eop ? (4'd8 - {1'b0, din_mty}) : 4'd8;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_start       = 1'b0;
        w_cont        = 1'b0;
        w_done        = 1'b0;
        w_proto_evt   = 1'b0;
        w_start_proto = 1'b0;
        if (w_acc) begin
            if (din_sop) begin
                // Any sop restarts framing; only cutting short a checked frame is a violation.
                w_proto_evt   = (r_state == IN_FRAME);
                w_start_proto = (r_state == IN_FRAME);
                if (ctl_vnc_mon_en) begin
                    w_start     = 1'b1;
                    w_done      = din_eop;
                    w_state_nxt = din_eop ? IDLE : IN_FRAME;
                end else begin
                    w_state_nxt = din_eop ? IDLE : SKIP;
                end
            end else begin
                case (r_state)
                    IN_FRAME: begin
                        w_cont = 1'b1;
                        if (din_eop) begin
                            w_done      = 1'b1;
                            w_state_nxt = IDLE;
                        end
                    end
                    SKIP: begin
                        if (din_eop) begin
                            w_state_nxt = IDLE;
                        end
                    end
                    default: w_proto_evt = 1'b1;
                endcase
            end
        end
    end

    assign w_base     = w_start ? '0 : r_len;
    assign w_base_sat = w_start ? 1'b0 : r_sat;
    assign w_sum      = {1'b0, w_base} + {{(LEN_W-3){1'b0}}, w_nbytes};
    assign w_sat_nxt  = w_base_sat | w_sum[LEN_W];
    assign w_len_nxt  = w_sat_nxt ? {LEN_W{1'b1}} : w_sum[LEN_W-1:0];

`ifdef GTFMAC_VNC_RX_CHK_PLD_EN
    localparam logic [LEN_W:0] c_pld_ofs = (LEN_W+1)'(PLD_OFS);

    logic       r_pld;
    logic [7:0] r_last;
    logic [7:0] w_lane_bad;

    // Lane k sits at frame offset base+k and is compared with its left neighbour,
    // or with the last byte of the previous beat for lane 0.
    for (genvar k = 0; k < 8; k++) begin : g_lane
        logic [LEN_W:0] w_pos;
        logic [7:0]     w_prev;
        assign w_pos = {1'b0, w_base} + (LEN_W+1)'(k);
        if (k == 0) begin : g_first
            assign w_prev = r_last;
        end else begin : g_rest
            assign w_prev = din_data[8*k-8 +: 8];
        end
        assign w_lane_bad[k] = (4'(k) < w_nbytes) && (w_pos > c_pld_ofs) &&
                               (din_data[8*k +: 8] != (w_prev + 8'd1));
    end

    assign w_pld_nxt = (w_start ? 1'b0 : r_pld) | (|w_lane_bad);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pld  <= 1'b0;
            r_last <= 8'd0;
        end else if (w_start || w_cont) begin
            r_pld  <= w_pld_nxt;
            r_last <= din_data[63:56];
        end
    end
`else
    logic w_unused;
    assign w_unused  = ^{din_data, 6'(PLD_OFS)};
    assign w_pld_nxt = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len   <= '0;
            r_sat   <= 1'b0;
            r_proto <= 1'b0;
        end else if (w_start || w_cont) begin
            r_len   <= w_len_nxt;
            r_sat   <= w_sat_nxt;
            r_proto <= w_start ? w_start_proto : r_proto;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frm_done   <= 1'b0;
            r_frm_len    <= '0;
            r_frm_status <= '0;
        end else begin
            r_frm_done <= w_done;
            if (w_done) begin
                r_frm_len          <= w_len_nxt;
                r_frm_status.proto <= w_start ? w_start_proto : r_proto;
                r_frm_status.err   <= din_err;
                r_frm_status.pld   <= w_pld_nxt;
                r_frm_status.over  <= w_sat_nxt | (w_len_nxt > ctl_vnc_max_len);
                r_frm_status.under <= (w_len_nxt < ctl_vnc_min_len);
            end
        end
    end

    assign frm_done   = r_frm_done;
    assign frm_len    = r_frm_len;
    assign frm_status = r_frm_status;

    // The proto status bit is informational; cnt_proto counts the violation event itself.
    gtfmac_vnc_sat_cnt #(.WIDTH(CNT_W)) u_cnt_good (
        .clk (clk), .rst (rst), .clr (clr_cnt),
        .inc (r_frm_done & ~(r_frm_status.under | r_frm_status.over |
                             r_frm_status.pld | r_frm_status.err)),
        .cnt (cnt_good)
    );

    gtfmac_vnc_sat_cnt #(.WIDTH(CNT_W)) u_cnt_under (
        .clk (clk), .rst (rst), .clr (clr_cnt),
        .inc (r_frm_done & r_frm_status.under),
        .cnt (cnt_under)
    );

    gtfmac_vnc_sat_cnt #(.WIDTH(CNT_W)) u_cnt_over (
        .clk (clk), .rst (rst), .clr (clr_cnt),
        .inc (r_frm_done & r_frm_status.over),
        .cnt (cnt_over)
    );

    gtfmac_vnc_sat_cnt #(.WIDTH(CNT_W)) u_cnt_pld (
        .clk (clk), .rst (rst), .clr (clr_cnt),
        .inc (r_frm_done & r_frm_status.pld),
        .cnt (cnt_pld_err)
    );

    gtfmac_vnc_sat_cnt #(.WIDTH(CNT_W)) u_cnt_err (
        .clk (clk), .rst (rst), .clr (clr_cnt),
        .inc (r_frm_done & r_frm_status.err),
        .cnt (cnt_err)
    );

    gtfmac_vnc_sat_cnt #(.WIDTH(CNT_W)) u_cnt_proto (
        .clk (clk), .rst (rst), .clr (clr_cnt),
        .inc (w_proto_evt),
        .cnt (cnt_proto)
    );

endmodule

`default_nettype wire

// File: doc/gtfmac_vnc_rx_pkt_chk.md
Name: gtfmac_vnc_rx_pkt_chk

Overview:
- Sits directly downstream of the RX GTFMAC interface normaliser in the RX monitor, on the rx_clk domain.
- Consumes its normalised packet stream (ena/sop/data/eop/mty/err/empty).
- Frames packets and checks each frame's length against ctl_vnc_min_len/ctl_vnc_max_len.
- Verifies an incrementing-byte payload pattern, emits a per-frame status pulse and keeps saturating per-category counters.

Parameters:
- CNT_W, 32, width of every statistics counter.
- PLD_OFS, 14, byte offset within the frame where payload pattern checking starts (0..63).
- LEN_W, 14, width of the frame length accumulator and length thresholds.

Ports:
- clk  in  1  RX user clock.
- rst  in  1  synchronous active-high reset.
- din_ena  in  1  beat qualifier.
- din_sop  in  1  first beat of frame.
- din_data  in  64  frame bytes; byte 0 = din_data[7:0].
- din_eop  in  1  last beat of frame.
- din_mty  in  3  empty bytes in the eop beat; valid lanes are 0..7-mty.
- din_err  in  1  frame error flag, meaningful on the eop beat.
- din_empty  in  1  beat carries no data.
- ctl_vnc_mon_en  in  1  checker enable, sampled at sop.
- ctl_vnc_min_len  in  LEN_W  minimum legal frame length in bytes.
- ctl_vnc_max_len  in  LEN_W  maximum legal frame length in bytes.
- clr_cnt  in  1  synchronous clear of all counters.
- frm_done  out  1  one-cycle pulse per completed checked frame.
- frm_len  out  LEN_W  length of the completed frame.
- frm_status  out  5  {proto, err, pld, over, under}, valid with frm_done.
- cnt_good  out  CNT_W  good frames.
- cnt_under  out  CNT_W  undersize frames.
- cnt_over  out  CNT_W  oversize frames.
- cnt_pld_err  out  CNT_W  frames with payload mismatch.
- cnt_err  out  CNT_W  frames ending with din_err.
- cnt_proto  out  CNT_W  protocol violations.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high. All outputs reset to 0; FSM resets to IDLE.
- Beat acceptance: a beat is accepted only when din_ena=1 and din_empty=0. All other cycles are ignored entirely.
- FSM IDLE:
  - Accepted sop with ctl_vnc_mon_en=1 → IN_FRAME; length is loaded with the byte count of this beat.
  - Accepted sop with ctl_vnc_mon_en=0 → SKIP.
  - Accepted non-sop beat → cnt_proto+1, stay in IDLE.
  - sop&eop on the same beat is a single-beat frame; it completes immediately and returns to IDLE.
- FSM IN_FRAME:
  - Each accepted beat adds 8 bytes (mty lanes excluded on the eop beat).
  - eop → frame complete, return to IDLE.
  - sop without a prior eop → cnt_proto+1. The open frame is abandoned with no frm_done; the new frame starts.
- FSM SKIP: consumes beats until eop → IDLE. Nothing is counted. An early sop is handled as in IN_FRAME but not counted.
- ctl_vnc_mon_en changes mid-frame have no effect on the frame in progress.
- Length arithmetic: saturates at 2^LEN_W-1. Once saturated, the frame is classed as over.
  - under when len < ctl_vnc_min_len.
  - over when len > ctl_vnc_max_len.
- Payload check:
  - The byte at offset PLD_OFS seeds the expectation.
  - Each subsequent valid byte must equal the previous byte + 1 mod 256.
  - Any mismatch sets the pld flag. Checking is per-lane within a beat and continues across beats.
  - A frame shorter than PLD_OFS+1 bytes is never flagged pld.
- Frame completion:
  - frm_done pulses exactly 1 cycle after the eop beat, with frm_len/frm_status registered. They hold until the next frm_done.
  - The same cycle, each counter matching a set status bit increments.
  - cnt_good increments only when under, over, pld and err are all 0.
  - A frame may increment several counters.
- Counters: saturate at all-ones.
  - clr_cnt zeroes them the next cycle. If clr_cnt coincides with an increment, the clear wins.
  - A protocol violation coincident with frm_done increments cnt_proto without affecting the frame counters.
- Back-to-back frames with no idle cycle must each produce frm_done.
- rst mid-frame discards the frame; no frm_done is produced.

Optional Feature:
- Macro: GTFMAC_VNC_RX_CHK_PLD_EN.
- Defined: payload checking as above.
- Undefined: no payload logic; frm_status[2]=0 and cnt_pld_err ties to 0. Everything else is unchanged.

Decomposition:
- Package gtfmac_vnc_rx_chk_pkg holds:
  - FSM state enum {IDLE, IN_FRAME, SKIP}.
  - Packed frm_status struct and its bit index constants.
  - Default CNT_W/LEN_W constants.
- Sub-module gtfmac_vnc_sat_cnt: a parameterised saturating counter with inc and clr. It is instantiated six times.

Test Plan:
- 64-byte frame (8 beats, mty=0, bytes 14..63 = 0x00..0x31), min=64, max=1518 → frm_done 1 cycle after eop, frm_len=64, status=0, cnt_good=1.
- 60-byte frame (mty=4) with min=64; then 1519-byte frame with max=1518 → cnt_under=1, cnt_over=1, cnt_good=0, frm_len=60 then 1519.
- 128-byte frame with byte 70 corrupted to 0xFF → frm_status[2]=1, cnt_pld_err=1. With the macro undefined → cnt_good=1.
- Protocol errors:
  - Data beat without sop → cnt_proto=1.
  - sop, 2 beats, second sop, then a 64-byte good frame → cnt_proto=2, exactly one frm_done, cnt_good=1.
- 10 back-to-back 64-byte frames with din_empty cycles interleaved → 10 frm_done pulses, cnt_good=10.
- Counter saturation and clear:
  - CNT_W=4, 20 good frames → cnt_good=15.
  - clr_cnt coincident with frm_done → cnt_good=0.
  - rst mid-frame → no frm_done, all counters 0.
